modn_count_sequencer: RTL and testbench
=======================================

Name: modn_count_sequencer

Overview:
- Command-driven controller for a mod-N up/down counter.
- Accepts one command at a time over a valid/ready handshake. Each command holds a direction and a step count.
- Advances the counter by that many steps at a programmable prescaled rate, wrapping within 0..N-1.
- Reports completion and wrap events. It sits between a host/CSR block and any logic that consumes the count value.

Parameters:
- N, 10, counter modulus; count range 0..N-1; N >= 2
- WIDTH, 4, count width; 2^WIDTH >= N
- STEPW, 8, width of the step-count field
- PRESCALE, 1, clock cycles per counter step; PRESCALE >= 1

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_dir  input  1  1 = count up, 0 = count down; sampled on handshake
- cmd_steps  input  STEPW  number of steps to execute; sampled on handshake
- hold  input  1  freeze prescaler and counter while in RUN
- abort  input  1  terminate the active command
- count  output  WIDTH  current counter value
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: command completed normally
- wrap  output  1  one-cycle pulse: the last step crossed N-1->0 (up) or 0->N-1 (down)
- steps_left  output  STEPW  steps remaining in the active command

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, count=0, steps_left=0, prescaler=0.
  - done=0, wrap=0, busy=0, cmd_ready=1 after deassertion.
  - Reset mid-command discards the command; count returns to 0.
- States:
  - IDLE: cmd_ready=1, busy=0.
    - On an edge with cmd_valid=1: latch dir and steps; load prescaler=PRESCALE-1.
    - steps!=0 -> RUN. steps==0 -> DONE directly; count unchanged.
  - RUN: cmd_ready=0, busy=1. Each cycle:
    - abort=1 -> IDLE; no step; no done; count keeps its value; steps_left cleared to 0.
    - else hold=1 -> nothing changes.
    - else prescaler!=0 -> decrement prescaler.
    - else (tick) -> step the counter; reload prescaler=PRESCALE-1; steps_left-=1. If steps_left was 1 -> DONE.
  - DONE: one cycle, done=1, busy=1, cmd_ready=0 -> IDLE. abort in DONE is ignored.
- Priority and conflicts:
  - Priority within RUN is abort > hold > tick.
  - abort and hold have no effect in IDLE.
  - cmd_valid outside IDLE is not accepted; the command stays pending at the source.
- Step arithmetic:
  - Up: count==N-1 -> 0 with wrap=1, else count+1.
  - Down: count==0 -> N-1 with wrap=1, else count-1.
  - wrap is registered and high in the cycle after the wrapping step only.
  - count never leaves 0..N-1.
  - Comparisons use the full WIDTH; no overflow of steps_left.
- Latency: for a command accepted at edge 0 with S>0 steps:
  - Steps occur at edges PRESCALE, 2*PRESCALE, ..., S*PRESCALE.
  - done is high in the cycle after edge S*PRESCALE.
  - cmd_ready returns one cycle later; back-to-back gap = 1 DONE cycle.
- Outputs are registered, except cmd_ready and busy, which are decoded from the state register.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - direction constants DIR_UP=1, DIR_DOWN=0
- Sub-module modn_step_core holds:
  - the mod-N up/down counter with enable, dir and wrap output
  - the same async active-low reset
- The sequencer holds the FSM, prescaler, step counter and handshake.

Test Plan:
- Reset then up command: reset low mid-run, release; send dir=1, steps=3 (N=10, PRESCALE=1) -> count=0 after reset; count 1,2,3 on edges 1..3; done pulse next cycle; cmd_ready high one cycle later.
- Up wrap: start count=8, dir=1, steps=4 -> count 9,0,1,2; wrap pulses once (after 9->0); done once.
- Down wrap with prescale: PRESCALE=3, count=1, dir=0, steps=2 -> count 0 at edge 3, 9 at edge 6; wrap after 0->9; steps_left 2,1,0.
- hold/abort: dir=1, steps=5; hold for 4 cycles after step 2 -> count frozen at 2. abort together with the next tick -> no step, IDLE next cycle, count=2, done never asserted.
- Zero-step and busy rejection: steps=0 -> done pulse, count unchanged. A second cmd_valid during RUN -> cmd_ready=0, command accepted only once back in IDLE, executes fully.

Source files
------------

// File: rtl/modn_count_sequencer_pkg.sv
// Shared definitions for the mod-N count sequencer.
// Holds the sequencer state encoding and the direction constants used by
// both the sequencer and its step core.
package modn_count_sequencer_pkg;

  // Sequencer states: wait for a command, execute it, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Direction field of a command.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/modn_step_core.sv
// Mod-N up/down counter that moves by one position per enabled cycle.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low reset (count returns to 0)
//   en    - perform one step on this edge
//   dir   - DIR_UP counts up, DIR_DOWN counts down
//   count - current value, always within 0..N-1
//   wrap  - registered pulse, high for the cycle after a step that wrapped
module modn_step_core
  import modn_count_sequencer_pkg::*;
#(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(N - 1);

  // One step per enabled edge; the boundary values wrap to the opposite end
  // and flag it, so count can never leave 0..N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en) begin
        if (dir == DIR_UP) begin
          if (count == MAXV) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          if (count == '0) begin
            count <= MAXV;
            wrap  <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/modn_count_sequencer.sv
// Command-driven controller for a mod-N up/down counter.
// Accepts one (direction, step count) command at a time over valid/ready and
// advances the counter by that many steps, one step every PRESCALE cycles.
// Ports:
//   clk, reset            - clock and asynchronous active-low reset
//   cmd_valid/cmd_ready   - command handshake (ready only in IDLE)
//   cmd_dir, cmd_steps    - command fields, sampled on the handshake
//   hold                  - freezes prescaler and counter while running
//   abort                 - drops the active command without completion
//   count                 - current counter value
//   busy                  - command in progress (RUN or DONE)
//   done                  - one-cycle pulse on normal completion
//   wrap                  - one-cycle pulse after a wrapping step
//   steps_left            - steps remaining in the active command
module modn_count_sequencer
  import modn_count_sequencer_pkg::*;
#(
  parameter int N        = 10,
  parameter int WIDTH    = 4,
  parameter int STEPW    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [STEPW-1:0] steps_left
);

  // A prescale of 1 still needs a one-bit register that simply stays at 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          dir_q;
  logic          tick;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN) || (state == DONE);

  // abort outranks hold, which outranks the prescaler expiring.
  assign tick = (state == RUN) && !abort && !hold && (prescaler == '0);

  // Sequencer FSM with prescaler and remaining-step bookkeeping. done is
  // raised together with the move into DONE so it is high exactly while
  // the FSM sits in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prescaler  <= '0;
      steps_left <= '0;
      dir_q      <= DIR_UP;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q      <= cmd_dir;
            steps_left <= cmd_steps;
            prescaler  <= RELOAD;
            if (cmd_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state      <= IDLE;
            steps_left <= '0;
          end else if (!hold) begin
            if (prescaler != '0) begin
              prescaler <= prescaler - 1'b1;
            end else begin
              prescaler  <= RELOAD;
              steps_left <= steps_left - 1'b1;
              if (steps_left == STEPW'(1)) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  modn_step_core #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .dir   (dir_q),
    .count (count),
    .wrap  (wrap)
  );

endmodule

// File: tb/tb_modn_count_sequencer.sv
// Directed self-checking bench for modn_count_sequencer.
// dut runs with PRESCALE=1, dut3 with PRESCALE=3; both use N=10.
module tb_modn_count_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid, cmd_dir, hold, abort;
  logic [7:0] cmd_steps;
  logic       cmd_ready, busy, done, wrap;
  logic [3:0] count;
  logic [7:0] steps_left;

  logic       p3_cmd_valid, p3_cmd_dir;
  logic [7:0] p3_cmd_steps;
  logic       p3_cmd_ready, p3_busy, p3_done, p3_wrap;
  logic [3:0] p3_count;
  logic [7:0] p3_steps_left;

  int checks   = 0;
  int failures = 0;

  modn_count_sequencer #(.N(10), .WIDTH(4), .STEPW(8), .PRESCALE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .hold       (hold),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap),
    .steps_left (steps_left)
  );

  modn_count_sequencer #(.N(10), .WIDTH(4), .STEPW(8), .PRESCALE(3)) dut3 (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (p3_cmd_valid),
    .cmd_ready  (p3_cmd_ready),
    .cmd_dir    (p3_cmd_dir),
    .cmd_steps  (p3_cmd_steps),
    .hold       (1'b0),
    .abort      (1'b0),
    .count      (p3_count),
    .busy       (p3_busy),
    .done       (p3_done),
    .wrap       (p3_wrap),
    .steps_left (p3_steps_left)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the PRESCALE=1 instance's inputs.
  task automatic applyStimulus(input logic v, input logic d, input logic [7:0] s,
                               input logic h, input logic a);
    cmd_valid = v;
    cmd_dir   = d;
    cmd_steps = s;
    hold      = h;
    abort     = a;
  endtask

  // One immediate assertion per comparison; failures are counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one edge (caller ensures cmd_ready).
  task automatic send(input logic d, input logic [7:0] s);
    applyStimulus(1'b1, d, s, 1'b0, 1'b0);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  logic [3:0] up_cnt  [4] = '{4'd9, 4'd0, 4'd1, 4'd2};
  logic       up_wrap [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [3:0] dn_cnt  [6] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd9};
  logic [7:0] dn_sl   [6] = '{8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
  logic       dn_wrap [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    p3_cmd_valid = 1'b0;
    p3_cmd_dir   = 1'b0;
    p3_cmd_steps = 8'd0;

    // Reset values
    #2;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wrap", wrap, 0);
    checkOutput("rst_steps_left", steps_left, 0);
    #10 reset = 1'b1;
    next_cycle();

    // Reset asserted in the middle of a command
    send(1'b1, 8'd5);
    next_cycle();
    next_cycle();
    checkOutput("midrun_count_before", count, 2);
    reset = 1'b0;
    #1;
    checkOutput("midrun_count", count, 0);
    checkOutput("midrun_busy", busy, 0);
    checkOutput("midrun_steps_left", steps_left, 0);
    checkOutput("midrun_ready", cmd_ready, 1);
    #2 reset = 1'b1;
    next_cycle();

    // Up by 3 from 0
    checkOutput("up3_ready_idle", cmd_ready, 1);
    send(1'b1, 8'd3);
    checkOutput("up3_busy", busy, 1);
    checkOutput("up3_sl_load", steps_left, 3);
    checkOutput("up3_count_load", count, 0);
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      checkOutput("up3_count", count, i);
      checkOutput("up3_sl", steps_left, 3 - i);
    end
    checkOutput("up3_done", done, 1);
    checkOutput("up3_ready_done", cmd_ready, 0);
    next_cycle();
    checkOutput("up3_done_clear", done, 0);
    checkOutput("up3_ready_back", cmd_ready, 1);
    checkOutput("up3_busy_clear", busy, 0);

    // Up wrap: bring count to 8, then up 4
    send(1'b1, 8'd5);
    for (int i = 0; i < 6; i++) next_cycle();
    checkOutput("prep8_count", count, 8);
    send(1'b1, 8'd4);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checkOutput("upwrap_count", count, up_cnt[i]);
      checkOutput("upwrap_wrap", wrap, up_wrap[i]);
    end
    checkOutput("upwrap_done", done, 1);
    next_cycle();
    checkOutput("upwrap_done_clear", done, 0);

    // hold and abort: back to 0, then up 5
    send(1'b0, 8'd2);
    for (int i = 0; i < 3; i++) next_cycle();
    checkOutput("prep0_count", count, 0);
    send(1'b1, 8'd5);
    next_cycle();
    next_cycle();
    checkOutput("hold_start_count", count, 2);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      checkOutput("hold_count", count, 2);
    end
    checkOutput("hold_sl", steps_left, 3);
    checkOutput("hold_busy", busy, 1);
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("abort_ready", cmd_ready, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_count", count, 2);
    checkOutput("abort_sl", steps_left, 0);
    checkOutput("abort_done", done, 0);
    next_cycle();
    checkOutput("abort_done_later", done, 0);
    checkOutput("abort_count_later", count, 2);

    // Zero-step command
    send(1'b1, 8'd0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_count", count, 2);
    checkOutput("zero_busy", busy, 1);
    checkOutput("zero_ready", cmd_ready, 0);
    next_cycle();
    checkOutput("zero_done_clear", done, 0);
    checkOutput("zero_ready_back", cmd_ready, 1);

    // Command offered while busy waits until IDLE
    send(1'b1, 8'd2);
    applyStimulus(1'b1, 1'b0, 8'd1, 1'b0, 1'b0);
    next_cycle();
    checkOutput("pend_count1", count, 3);
    checkOutput("pend_ready_run", cmd_ready, 0);
    next_cycle();
    checkOutput("pend_count2", count, 4);
    checkOutput("pend_first_done", done, 1);
    next_cycle();
    checkOutput("pend_ready_idle", cmd_ready, 1);
    checkOutput("pend_count_idle", count, 4);
    next_cycle();
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    checkOutput("pend_accept_busy", busy, 1);
    checkOutput("pend_accept_sl", steps_left, 1);
    checkOutput("pend_accept_count", count, 4);
    next_cycle();
    checkOutput("pend_exec_count", count, 3);
    checkOutput("pend_exec_done", done, 1);
    next_cycle();
    checkOutput("pend_final_ready", cmd_ready, 1);

    // PRESCALE=3 instance: reach count 1, then down 2 with wrap
    p3_cmd_valid = 1'b1;
    p3_cmd_dir   = 1'b1;
    p3_cmd_steps = 8'd1;
    next_cycle();
    p3_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) next_cycle();
    checkOutput("p3_prep_count", p3_count, 1);
    checkOutput("p3_prep_ready", p3_cmd_ready, 1);
    p3_cmd_valid = 1'b1;
    p3_cmd_dir   = 1'b0;
    p3_cmd_steps = 8'd2;
    next_cycle();
    p3_cmd_valid = 1'b0;
    checkOutput("p3_load_sl", p3_steps_left, 2);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      checkOutput("p3_count", p3_count, dn_cnt[i]);
      checkOutput("p3_sl", p3_steps_left, dn_sl[i]);
      checkOutput("p3_wrap", p3_wrap, dn_wrap[i]);
    end
    checkOutput("p3_done", p3_done, 1);
    next_cycle();
    checkOutput("p3_wrap_clear", p3_wrap, 0);
    checkOutput("p3_done_clear", p3_done, 0);
    checkOutput("p3_ready_back", p3_cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
